// File: rtl/dma_local_responder.sv
// dma_local_responder: host-side DMA endpoint backed by on-chip RAM.
// Ports: rd_* read channel into a FWFT prefetch FIFO; wr_* write channel
// committing straight to RAM; err_count built only with DMA_RESP_ERR_CNT_EN.
module dma_local_responder #(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 64,
  parameter int SIZE_WIDTH     = 43,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [SIZE_WIDTH-1:0] rd_size,
  input  logic                  rd_go,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  rd_done,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [SIZE_WIDTH-1:0] wr_size,
  input  logic                  wr_go,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  wr_done,
  output logic [15:0]           err_count
);

  localparam int LW = MEM_DEPTH_LOG2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FDEPTH = CW'(FIFO_DEPTH);

  localparam logic [1:0] RD_IDLE   = 2'd0;
  localparam logic [1:0] RD_ACTIVE = 2'd1;
  localparam logic [1:0] RD_DONE   = 2'd2;
  localparam logic [1:0] WR_IDLE   = 2'd0;
  localparam logic [1:0] WR_ACTIVE = 2'd1;
  localparam logic [1:0] WR_DONE   = 2'd2;

  logic [DATA_WIDTH-1:0] mem [2**LW];
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  ram_vld;

  logic [1:0]            rd_state;
  logic [LW-1:0]         rd_base;
  logic [SIZE_WIDTH-1:0] rd_len;
  logic [SIZE_WIDTH-1:0] issued;
  logic [SIZE_WIDTH-1:0] popped;
  logic [SIZE_WIDTH-1:0] popped_nx;
  logic [LW-1:0]         rd_idx;

  logic [DATA_WIDTH-1:0] fifo [FIFO_DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         fifo_cnt;
  logic                  issue;
  logic                  push;
  logic                  pop;

  logic [1:0]            wr_state;
  logic [LW-1:0]         wr_base;
  logic [SIZE_WIDTH-1:0] wr_len;
  logic [SIZE_WIDTH-1:0] written;
  logic [SIZE_WIDTH-1:0] written_nx;
  logic [LW-1:0]         wr_idx;
  logic                  wr_fire;

  logic unused_bits;
  assign unused_bits = ^{rd_addr[5:0], rd_addr[ADDR_WIDTH-1:6+LW],
                         wr_addr[5:0], wr_addr[ADDR_WIDTH-1:6+LW]};

  assign empty   = (fifo_cnt == '0);
  assign rd_data = empty ? '0 : fifo[head];
  assign rd_done = (rd_state == RD_DONE);

  // Credit counts the in-flight RAM read so the FIFO can never overflow.
  assign issue = !rd_go && (rd_state == RD_ACTIVE) &&
                 (issued < rd_len) &&
                 ((fifo_cnt + CW'(ram_vld)) < FDEPTH);
  assign push      = ram_vld && !rd_go;
  assign pop       = rd_en && !empty && !rd_go;
  assign popped_nx = popped + SIZE_WIDTH'(1);
  assign rd_idx    = rd_base + issued[LW-1:0];

  assign full       = (wr_state != WR_ACTIVE);
  assign wr_done    = (wr_state == WR_DONE);
  assign wr_fire    = wr_en && !full && !wr_go;
  assign written_nx = written + SIZE_WIDTH'(1);
  assign wr_idx     = wr_base + written[LW-1:0];

  // Read-first: a same-line write lands after the read samples.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_idx] <= wr_data;
    if (issue)   ram_q <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (push) fifo[tail] <= ram_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      rd_base  <= '0;
      rd_len   <= '0;
      issued   <= '0;
      popped   <= '0;
      head     <= '0;
      tail     <= '0;
      fifo_cnt <= '0;
      ram_vld  <= 1'b0;
    end else if (rd_go) begin
      rd_base  <= rd_addr[6 +: LW];
      rd_len   <= rd_size;
      issued   <= '0;
      popped   <= '0;
      head     <= '0;
      tail     <= '0;
      fifo_cnt <= '0;
      ram_vld  <= 1'b0;
      rd_state <= (rd_size == '0) ? RD_DONE : RD_ACTIVE;
    end else begin
      ram_vld <= issue;
      if (issue) issued <= issued + SIZE_WIDTH'(1);
      if (push)  tail <= tail + PW'(1);
      if (pop) begin
        head   <= head + PW'(1);
        popped <= popped_nx;
        if (popped_nx == rd_len) rd_state <= RD_DONE;
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= WR_IDLE;
      wr_base  <= '0;
      wr_len   <= '0;
      written  <= '0;
    end else if (wr_go) begin
      wr_base  <= wr_addr[6 +: LW];
      wr_len   <= wr_size;
      written  <= '0;
      wr_state <= (wr_size == '0) ? WR_DONE : WR_ACTIVE;
    end else if (wr_fire) begin
      written <= written_nx;
      if (written_nx == wr_len) wr_state <= WR_DONE;
    end
  end

`ifdef DMA_RESP_ERR_CNT_EN
  logic        err_hit;
  logic [15:0] err_q;

  assign err_hit = (rd_en && empty) || (wr_en && full) ||
                   (rd_en && rd_go) || (wr_en && wr_go);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (err_hit && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 16'h0;
`endif

endmodule

// File: tb/tb_dma_local_responder.sv
// tb_dma_local_responder: randomized self-checking bench.
// Line-addressed memory model; each test task checks inline.
module tb_dma_local_responder;

  localparam int DW = 512;
  localparam int AW = 64;
  localparam int SW = 43;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [SW-1:0] rd_size;
  logic          rd_go;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          rd_done;
  logic [AW-1:0] wr_addr;
  logic [SW-1:0] wr_size;
  logic          wr_go;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          wr_done;
  logic [15:0]   err_count;

  dma_local_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_size   (rd_size),
    .rd_go     (rd_go),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .rd_done   (rd_done),
    .wr_addr   (wr_addr),
    .wr_size   (wr_size),
    .wr_go     (wr_go),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .wr_done   (wr_done),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] model [1024];

  function automatic int line_of(logic [63:0] addr, int i);
    return int'(((addr >> 6) + 64'(i)) % 64'd1024);
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_addr = '0; rd_size = '0; rd_go = 0; rd_en = 0;
    wr_addr = '0; wr_size = '0; wr_go = 0; wr_en = 0;
    wr_data = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) step();
    rst_n = 1;
    step();
  endtask

  task automatic write_lines(input logic [63:0] addr,
                             input logic [DW-1:0] lines[$],
                             output int stalls);
    int guard;
    stalls = 0;
    wr_addr = addr;
    wr_size = SW'(lines.size());
    wr_go = 1;
    step();
    wr_go = 0;
    for (int i = 0; i < lines.size(); i++) begin
      guard = 0;
      while (full && guard < 20) begin
        stalls++; guard++; step();
      end
      wr_en = 1;
      wr_data = lines[i];
      step();
      model[line_of(addr, i)] = lines[i];
    end
    wr_en = 0;
  endtask

  task automatic read_lines(input logic [63:0] addr, input int size,
                            input int period, input int target,
                            output logic [DW-1:0] got[$],
                            output int first_t, output bit early);
    got = {};
    first_t = -1;
    early = 0;
    rd_addr = addr;
    rd_size = SW'(size);
    rd_en = 0;
    rd_go = 1;
    step();
    rd_go = 0;
    for (int t = 1; t < 400 && got.size() < target; t++) begin
      if (first_t < 0 && !empty) first_t = t;
      if (rd_done && got.size() < size) early = 1;
      rd_en = (t % period == 0);
      if (rd_en && !empty) got.push_back(rd_data);
      step();
    end
    rd_en = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (empty !== 1'b1) begin fails++;
        $display("FAIL reset_empty got %b exp 1", empty); end
      tests++;
      if (full !== 1'b1) begin fails++;
        $display("FAIL reset_full got %b exp 1", full); end
      tests++;
      if (rd_done !== 1'b0 || wr_done !== 1'b0) begin fails++;
        $display("FAIL reset_done got %b%b exp 00", rd_done, wr_done); end
      tests++;
      if (rd_data !== '0) begin fails++;
        $display("FAIL reset_rd_data got %h exp 0", rd_data); end
      tests++;
      if (err_count !== 16'h0) begin fails++;
        $display("FAIL reset_err got %0d exp 0", err_count); end
      repeat (3) step();
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] lines[$];
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp;
    int stalls, first_t;
    bit early;
    for (int i = 0; i < 4; i++) lines.push_back(DW'(32'hA0 + i));
    write_lines(64'h1000, lines, stalls);
    tests++;
    if (stalls !== 0) begin fails++;
      $display("FAIL wr_stalls got %0d exp 0", stalls); end
    tests++;
    if (wr_done !== 1'b1 || full !== 1'b1) begin fails++;
      $display("FAIL wr_done got done=%b full=%b exp 1 1", wr_done, full); end
    read_lines(64'h1000, 4, 1, 4, got, first_t, early);
    tests++;
    if (first_t !== 3) begin fails++;
      $display("FAIL first_latency got %0d exp 3", first_t); end
    tests++;
    if (got.size() !== 4) begin fails++;
      $display("FAIL wr_rd_count got %0d exp 4", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      exp = DW'(32'hA0 + i);
      tests++;
      if (got[i] !== exp) begin fails++;
        $display("FAIL wr_rd_line%0d got %h exp %h", i, got[i], exp); end
    end
    tests++;
    if (rd_done !== 1'b1 || empty !== 1'b1 || early) begin fails++;
      $display("FAIL rd_done got done=%b empty=%b early=%b exp 1 1 0",
               rd_done, empty, early); end
  endtask

  task automatic test_throttle();
    logic [DW-1:0] lines[$];
    logic [DW-1:0] got[$];
    logic [63:0] base;
    int stalls, first_t;
    bit early;
    base = {$urandom(), $urandom()};
    for (int i = 0; i < 8; i++) lines.push_back(rand_line());
    write_lines(base, lines, stalls);
    read_lines(base, 8, 3, 8, got, first_t, early);
    tests++;
    if (got.size() !== 8) begin fails++;
      $display("FAIL thr_count got %0d exp 8", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      tests++;
      if (got[i] !== model[line_of(base, i)]) begin fails++;
        $display("FAIL thr_line%0d got %h exp %h",
                 i, got[i], model[line_of(base, i)]); end
    end
    tests++;
    if (early || rd_done !== 1'b1) begin fails++;
      $display("FAIL thr_done got early=%b done=%b exp 0 1", early, rd_done); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] lines[$];
    logic [DW-1:0] got[$];
    int stalls, first_t;
    bit early;
    lines.push_back(rand_line());
    lines.push_back(rand_line());
    write_lines(64'hFFC0, lines, stalls);
    read_lines(64'hFFC0, 2, 1, 2, got, first_t, early);
    tests++;
    if (got.size() !== 2 || got[0] !== lines[0] || got[1] !== lines[1])
    begin fails++;
      $display("FAIL wrap_read got n=%0d exp 2 lines %h %h",
               got.size(), lines[0], lines[1]); end
    read_lines(64'h1_0025, 1, 1, 1, got, first_t, early);
    tests++;
    if (got.size() !== 1 || got[0] !== lines[1]) begin fails++;
      $display("FAIL wrap_alias got n=%0d exp line %h", got.size(), lines[1]);
    end
    read_lines(64'hDEAD_0000_0001_0000, 1, 1, 1, got, first_t, early);
    tests++;
    if (got.size() !== 1 || got[0] !== lines[1]) begin fails++;
      $display("FAIL wrap_high got n=%0d exp line %h", got.size(), lines[1]);
    end
  endtask

  task automatic test_zero_restart();
    logic [DW-1:0] la[$];
    logic [DW-1:0] lb[$];
    logic [DW-1:0] got[$];
    logic [63:0] a, b;
    int stalls, first_t;
    bit early;
    rd_addr = 64'h40; rd_size = '0; rd_go = 1;
    step();
    rd_go = 0;
    tests++;
    if (rd_done !== 1'b1 || empty !== 1'b1) begin fails++;
      $display("FAIL zero_size got done=%b empty=%b exp 1 1", rd_done, empty);
    end
    a = 64'(($urandom() % 512) * 64);
    b = a + 64'h400;
    for (int i = 0; i < 6; i++) la.push_back(rand_line());
    for (int i = 0; i < 3; i++) lb.push_back(rand_line());
    write_lines(a, la, stalls);
    write_lines(b, lb, stalls);
    read_lines(a, 6, 1, 2, got, first_t, early);
    tests++;
    if (got.size() !== 2 || got[0] !== la[0] || got[1] !== la[1]
        || rd_done !== 1'b0) begin fails++;
      $display("FAIL partial got n=%0d done=%b exp 2 0", got.size(), rd_done);
    end
    read_lines(b, 3, 1, 3, got, first_t, early);
    tests++;
    if (first_t !== 3) begin fails++;
      $display("FAIL restart_latency got %0d exp 3", first_t); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (i >= got.size() || got[i] !== lb[i]) begin fails++;
        $display("FAIL restart_line%0d got n=%0d exp %h", i, got.size(), lb[i]);
      end
    end
    tests++;
    if (rd_done !== 1'b1) begin fails++;
      $display("FAIL restart_done got %b exp 1", rd_done); end
  endtask

  task automatic test_random();
    logic [DW-1:0] lines[$];
    logic [DW-1:0] got[$];
    logic [63:0] base;
    int n, stalls, first_t, period;
    bit early;
    for (int it = 0; it < 6; it++) begin
      base = {$urandom(), $urandom()};
      n = $urandom_range(1, 12);
      period = $urandom_range(1, 3);
      lines = {};
      for (int i = 0; i < n; i++) lines.push_back(rand_line());
      write_lines(base, lines, stalls);
      read_lines(base, n, period, n, got, first_t, early);
      tests++;
      if (got.size() !== n || early || rd_done !== 1'b1) begin fails++;
        $display("FAIL rand%0d_count got n=%0d early=%b done=%b exp %0d 0 1",
                 it, got.size(), early, rd_done, n); end
      for (int i = 0; i < got.size(); i++) begin
        tests++;
        if (got[i] !== model[line_of(base, i)]) begin fails++;
          $display("FAIL rand%0d_line%0d got %h exp %h",
                   it, i, got[i], model[line_of(base, i)]); end
      end
    end
  endtask

  task automatic test_errors();
    logic [DW-1:0] lines[$];
    logic [15:0] exp_err;
    int stalls;
`ifdef DMA_RESP_ERR_CNT_EN
    exp_err = 16'd5;
`else
    exp_err = 16'd0;
`endif
    apply_reset();
    rd_en = 1;
    repeat (3) step();
    rd_en = 0;
    wr_en = 1;
    repeat (2) step();
    wr_en = 0;
    step();
    tests++;
    if (err_count !== exp_err) begin fails++;
      $display("FAIL err_count got %0d exp %0d", err_count, exp_err); end
    for (int i = 0; i < 4; i++) lines.push_back(rand_line());
    write_lines(64'h2000, lines, stalls);
    wr_addr = 64'h3000; wr_size = SW'(4); wr_go = 1;
    rd_addr = 64'h2000; rd_size = SW'(4); rd_go = 1;
    step();
    wr_go = 0; rd_go = 0;
    repeat (3) step();
    tests++;
    if (empty !== 1'b0 || full !== 1'b0) begin fails++;
      $display("FAIL mid_active got empty=%b full=%b exp 0 0", empty, full);
    end
    rst_n = 0;
    #1;
    tests++;
    if (empty !== 1'b1 || full !== 1'b1 || rd_done !== 1'b0
        || wr_done !== 1'b0) begin fails++;
      $display("FAIL mid_reset got e=%b f=%b rd=%b wd=%b exp 1 1 0 0",
               empty, full, rd_done, wr_done); end
    step();
    rst_n = 1;
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_throttle();
    test_wrap();
    test_zero_restart();
    test_random();
    test_errors();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
